edge_trig_decoder: RTL

// - Receive end of the edge-trigger sum/difference stream. Per word: XOUT, operand B, SEL (1 = add path used).
// - Recovers operand A, checks that the path choice matches A > B, and queues results for a downstream consumer.
// - Sits after the registered EdgeTrig producer, decoupled by valid/ready handshakes on both sides.

---
 rtl/edge_trig_decoder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/edge_trig_decoder.sv
// edge_trig_decoder: receive end of the edge-trigger sum/difference stream.
// Recovers operand A from XOUT/B/SEL, flags words whose path choice does not
// agree with A > B, and queues {A, ERR} in a DEPTH-entry FIFO for the consumer.
// Optional error statistics (ERR_CNT/CLR_STATS) are built when the macro
// EDGE_TRIG_DEC_STATS_EN is defined.
module edge_trig_decoder #(
    parameter int unsigned NBITS = 8,
    parameter int unsigned DEPTH = 4
`ifdef EDGE_TRIG_DEC_STATS_EN
    ,
    parameter int unsigned CNT_BITS = 16
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [NBITS-1:0] XOUT,
    input  logic [NBITS-1:0] B,
    input  logic             SEL,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [NBITS-1:0] A,
    output logic             ERR
`ifdef EDGE_TRIG_DEC_STATS_EN
    ,
    output logic [CNT_BITS-1:0] ERR_CNT,
    input  logic                CLR_STATS
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_e;

    logic [NBITS-1:0] a_rec;
    logic             err_rec;
    logic             push;
    logic             pop;
    occ_e             occ;

    logic [NBITS-1:0] mem_a [DEPTH];
    logic             mem_e [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    // Decode the incoming word and check the path choice against A > B.
    always_comb begin
        a_rec   = SEL ? (XOUT - B) : (XOUT + B);
        err_rec = SEL ? !(a_rec > B) : (a_rec > B);
    end

    // Occupancy class and handshakes; ready depends only on registered count.
    always_comb begin
        occ = OCC_PARTIAL;
        if (count_q == '0) begin
            occ = OCC_EMPTY;
        end else if (count_q == DEPTH_C) begin
            occ = OCC_FULL;
        end
        IN_READY  = !RST && (occ != OCC_FULL);
        OUT_VALID = (occ != OCC_EMPTY);
        push      = IN_VALID && IN_READY;
        pop       = OUT_VALID && OUT_READY;
        A         = OUT_VALID ? mem_a[rd_ptr_q] : '0;
        ERR       = OUT_VALID ? mem_e[rd_ptr_q] : 1'b0;
    end

    // Next-state for pointers and count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO occupancy state; async reset drops all queued words.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are masked by OUT_VALID so no reset is needed.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_a[wr_ptr_q] <= a_rec;
            mem_e[wr_ptr_q] <= err_rec;
        end
    end

`ifdef EDGE_TRIG_DEC_STATS_EN
    logic [CNT_BITS-1:0] err_cnt_q, err_cnt_d;

    // Saturating error counter; clear takes priority over an increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (CLR_STATS) begin
            err_cnt_d = '0;
        end else if (push && err_rec && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_BITS'(1);
        end
    end

    // Error counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ERR_CNT = err_cnt_q;
`endif

endmodule
